alu_op_sequencer: RTL

Parametrised control unit that sequences one operation at a time across NUM_UNITS functional units (unit 0 = adder/subtractor, unit 1 = multiplier, unit 2 = divider, further units by index).
- Accepts opcodes through a req/ready handshake and issues a one-cycle start pulse to the selected unit.
- Waits on that unit's own done bit, then reports completion, an illegal opcode, a timeout, or an abort.
- Sits between the ALU top-level operation select and the arithmetic units.

---
 rtl/alu_op_sequencer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Issues one operation at a time to NUM_UNITS functional units.
//               Accepts an opcode over a req/ready handshake, pulses start
//               to the selected unit, waits for that unit's done flag, and
//               reports completion, illegal opcode, timeout or abort.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
  parameter int NUM_UNITS = 3,
  parameter int OP_W      = 2,
  parameter int TO_W      = 8,
  parameter int TIMEOUT   = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic [OP_W-1:0]      op,
  input  logic                 abort,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic                 ready,
  output logic [NUM_UNITS-1:0] start,
  output logic                 sub,
  output logic                 busy,
  output logic [OP_W-1:0]      cur_op,
  output logic                 op_done,
  output logic                 err,
  output logic [1:0]           err_code
);

  // State encoding
  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_wait  = 2'd2;
  localparam logic [1:0] c_st_resp  = 2'd3;

  // Error codes reported on err_code
  localparam logic [1:0] c_err_none    = 2'b00;
  localparam logic [1:0] c_err_illegal = 2'b01;
  localparam logic [1:0] c_err_timeout = 2'b10;
  localparam logic [1:0] c_err_abort   = 2'b11;

  // Opcode constants; the extra bit lets NUM_UNITS be compared without overflow
  localparam logic [OP_W-1:0] c_op_sub = OP_W'(1);
  localparam logic [OP_W:0]   c_max_op = (OP_W + 1)'(NUM_UNITS);

  // Timeout constants; c_to_last is only meaningful when the timeout is enabled
  localparam logic            c_to_en   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] c_to_last = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic [NUM_UNITS-1:0] r_sel_mask;
  logic [TO_W-1:0]      r_timer;

  logic [NUM_UNITS-1:0] w_sel_mask;
  logic                 w_illegal;
  logic                 w_unit_done;
  logic                 w_timeout;

  logic [NUM_UNITS-1:0] w_start_nx;
  logic [NUM_UNITS-1:0] w_sel_nx;
  logic                 w_sub_nx;
  logic                 w_busy_nx;
  logic [OP_W-1:0]      w_cur_op_nx;
  logic                 w_op_done_nx;
  logic                 w_err_nx;
  logic [1:0]           w_err_code_nx;
  logic [TO_W-1:0]      w_timer_nx;

  // Opcodes 0 (add) and 1 (sub) share unit 0; opcode k>=2 selects unit k-1.
  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_sel
    if (i == 0) begin : g_unit0
      assign w_sel_mask[i] = ({1'b0, op} <= {1'b0, c_op_sub});
    end else begin : g_unitn
      localparam logic [OP_W:0] c_unit_op = (OP_W + 1)'(i + 1);
      assign w_sel_mask[i] = ({1'b0, op} == c_unit_op);
    end
  end

  assign w_illegal   = ({1'b0, op} > c_max_op);
  // Only the selected unit's done bit matters; all others are masked off.
  assign w_unit_done = |(unit_done & r_sel_mask);
  assign w_timeout   = c_to_en && (r_timer == c_to_last);

  // The only combinational output: the handshake is open exactly in IDLE.
  assign ready = (r_state == c_st_idle);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; in WAIT the priority is abort > done > timeout
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
        if (req && !w_illegal) begin
          w_next_state = c_st_issue;
        end
      end
      c_st_issue: begin
        // A done seen here is stale (left over from a prior op) and ignored.
        w_next_state = abort ? c_st_idle : c_st_wait;
      end
      c_st_wait: begin
        if (abort) begin
          w_next_state = c_st_idle;
        end else if (w_unit_done) begin
          w_next_state = c_st_resp;
        end else if (w_timeout) begin
          w_next_state = c_st_idle;
        end
      end
      c_st_resp: begin
        w_next_state = c_st_idle;
      end
      default: begin
        w_next_state = c_st_idle;
      end
    endcase
  end

  // Output decode: next values of every registered output and the timer
  always_comb begin
    w_start_nx    = '0;
    w_sel_nx      = r_sel_mask;
    w_sub_nx      = sub;
    w_cur_op_nx   = cur_op;
    w_op_done_nx  = 1'b0;
    w_err_nx      = 1'b0;
    w_err_code_nx = err_code;
    w_timer_nx    = r_timer;
    case (r_state)
      c_st_idle: begin
        if (req) begin
          w_cur_op_nx   = op;
          w_err_code_nx = c_err_none;
          if (w_illegal) begin
            w_err_nx      = 1'b1;
            w_err_code_nx = c_err_illegal;
          end else begin
            w_sub_nx   = (op == c_op_sub);
            w_sel_nx   = w_sel_mask;
            w_start_nx = w_sel_mask;
          end
        end
      end
      c_st_issue: begin
        w_timer_nx = '0;
        if (abort) begin
          w_err_nx      = 1'b1;
          w_err_code_nx = c_err_abort;
        end
      end
      c_st_wait: begin
        if (abort) begin
          w_err_nx      = 1'b1;
          w_err_code_nx = c_err_abort;
        end else if (w_unit_done) begin
          w_op_done_nx = 1'b1;
        end else if (w_timeout) begin
          w_err_nx      = 1'b1;
          w_err_code_nx = c_err_timeout;
        end else if (r_timer != '1) begin
          // Saturate rather than wrap so a disabled timeout never aliases.
          w_timer_nx = r_timer + 1'b1;
        end
      end
      default: begin
      end
    endcase
    // Subtract mode only lives for the duration of an operation.
    if (w_next_state == c_st_idle) begin
      w_sub_nx = 1'b0;
    end
    w_busy_nx = (w_next_state != c_st_idle);
  end

  // Output and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start      <= '0;
      r_sel_mask <= '0;
      sub        <= 1'b0;
      busy       <= 1'b0;
      cur_op     <= '0;
      op_done    <= 1'b0;
      err        <= 1'b0;
      err_code   <= c_err_none;
      r_timer    <= '0;
    end else begin
      start      <= w_start_nx;
      r_sel_mask <= w_sel_nx;
      sub        <= w_sub_nx;
      busy       <= w_busy_nx;
      cur_op     <= w_cur_op_nx;
      op_done    <= w_op_done_nx;
      err        <= w_err_nx;
      err_code   <= w_err_code_nx;
      r_timer    <= w_timer_nx;
    end
  end

endmodule
`default_nettype wire
